// File: rtl/fht_stream_io_pkg.sv
// fht_defines: shared FSM encoding and frame geometry helpers for the FHT streaming wrapper
package fht_defines;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_CALC,
        ST_UNLOAD
    } state_t;

    function automatic int bank_count(input int nb_log2);
        return 1 << nb_log2;
    endfunction

    function automatic int frame_len(input int a_bit, input int nb_log2);
        return 1 << (a_bit + nb_log2);
    endfunction

endpackage

// File: rtl/fht_stream_io_skid_buf.sv
// fht_skid_buf: two-entry output FIFO; head is a register so data holds steady under back-pressure
module fht_skid_buf #(
    parameter int D_BIT = 20
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iFLUSH,
    input  logic             iPUSH,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iPOP,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    output logic [1:0]       oCOUNT
);

    logic [D_BIT-1:0] r_d0;
    logic [D_BIT-1:0] r_d1;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop  = iPOP && (r_cnt != 2'd0);
    assign oDATA  = r_d0;
    assign oVALID = (r_cnt != 2'd0);
    assign oCOUNT = r_cnt;

    // entry 0 is always the head; a pop shifts entry 1 forward, a push fills the first free slot
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else if (iFLUSH) begin
            r_cnt <= 2'd0;
        end else begin
            case ({iPUSH, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= iDATA;
                    else r_d1 <= iDATA;
                    if (r_cnt != 2'd2) r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) r_d0 <= iDATA;
                    else begin
                        r_d0 <= r_d1;
                        r_d1 <= iDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fht_stream_io.sv
// fht_stream_io: streams a frame into banked FHT core memory, starts the core, and streams results out
module fht_stream_io
    import fht_defines::*;
#(
    parameter int D_BIT   = 20,
    parameter int IN_BIT  = 16,
    parameter int A_BIT   = 8,
    parameter int NB_LOG2 = 2,
    localparam int NB     = bank_count(NB_LOG2),
    localparam int N      = frame_len(A_BIT, NB_LOG2),
    localparam int I_BIT  = A_BIT + NB_LOG2
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iCLR,
    input  logic [IN_BIT-1:0]     iS_DATA,
    input  logic                  iS_VALID,
    output logic                  oS_READY,
    output logic [NB-1:0]         oWE,
    output logic [D_BIT-1:0]      oDATA_WR,
    output logic [A_BIT-1:0]      oADDR_WR,
    output logic                  oSTART,
    input  logic                  iRDY,
    output logic [NB*A_BIT-1:0]   oADDR_RD,
    input  logic [NB*D_BIT-1:0]   iDATA_RD,
    output logic [D_BIT-1:0]      oM_DATA,
    output logic                  oM_VALID,
    input  logic                  iM_READY,
    output logic                  oM_LAST,
    output logic                  oBUSY,
    output logic [15:0]           oFRAME_CNT
);

    localparam logic [I_BIT-1:0] IDX_LAST = I_BIT'(N - 1);
    localparam logic [I_BIT-1:0] IDX_ONE  = I_BIT'(1);
    localparam logic [I_BIT:0]   RIDX_ONE = (I_BIT + 1)'(1);
    localparam logic [A_BIT-1:0] ADDR_ONE = A_BIT'(1);

    state_t               r_state;
    logic                 r_rdy;
    logic                 r_start;
    logic                 r_low;
    logic [I_BIT-1:0]     r_widx;
    logic [I_BIT-1:0]     r_oidx;
    logic [I_BIT:0]       r_ridx;
    logic [A_BIT-1:0]     r_raddr [NB];
    logic                 r_inf;
    logic [NB_LOG2-1:0]   r_inf_bank;
    logic [15:0]          r_fcnt;

    logic                 w_acc;
    logic                 w_issue;
    logic                 w_pop;
    logic                 w_valid;
    logic                 w_last_out;
    logic [1:0]           w_cnt;
    logic [2:0]           w_occ;
    logic [NB_LOG2-1:0]   w_rbank;
    logic [D_BIT-1:0]     w_push_data;
    logic [D_BIT-1:0]     w_mdata;

    assign w_acc    = (r_state == ST_LOAD) && r_rdy && iS_VALID && !iCLR;
    assign oWE      = w_acc ? NB'(1) << r_widx[NB_LOG2-1:0] : '0;
    assign oDATA_WR = D_BIT'($signed(iS_DATA));
    assign oADDR_WR = r_widx[I_BIT-1:NB_LOG2];
    assign oS_READY = r_rdy;
    assign oSTART   = r_start;
    assign oBUSY    = (r_state != ST_LOAD);
    assign oFRAME_CNT = r_fcnt;

    assign w_rbank     = r_ridx[NB_LOG2-1:0];
    assign w_pop       = w_valid && iM_READY;
    assign w_occ       = {1'b0, w_cnt} + {2'b00, r_inf} - {2'b00, w_pop};
    assign w_issue     = (r_state == ST_UNLOAD) && !r_ridx[I_BIT] && (w_occ < 3'd2) && !iCLR;
    assign w_last_out  = w_pop && (r_oidx == IDX_LAST);
    assign w_push_data = iDATA_RD[r_inf_bank*D_BIT +: D_BIT];

    assign oM_DATA  = w_mdata;
    assign oM_VALID = w_valid;
    assign oM_LAST  = w_valid && (r_oidx == IDX_LAST);

    for (genvar b = 0; b < NB; b++) begin : g_raddr
        assign oADDR_RD[b*A_BIT +: A_BIT] = r_raddr[b];
    end

    // frame sequencer; each bank read address is pre-set to that bank's next read so it is valid on issue
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= ST_LOAD;
            r_rdy      <= 1'b0;
            r_start    <= 1'b0;
            r_low      <= 1'b0;
            r_widx     <= '0;
            r_oidx     <= '0;
            r_ridx     <= '0;
            r_inf      <= 1'b0;
            r_inf_bank <= '0;
            r_fcnt     <= 16'd0;
            for (int i = 0; i < NB; i++) r_raddr[i] <= '0;
        end else if (iCLR) begin
            r_state <= ST_LOAD;
            r_rdy   <= 1'b1;
            r_start <= 1'b0;
            r_low   <= 1'b0;
            r_widx  <= '0;
            r_oidx  <= '0;
            r_ridx  <= '0;
            r_inf   <= 1'b0;
            for (int i = 0; i < NB; i++) r_raddr[i] <= '0;
        end else begin
            r_inf      <= w_issue;
            r_inf_bank <= w_rbank;
            r_start    <= 1'b0;
            if (w_issue) begin
                r_ridx           <= r_ridx + RIDX_ONE;
                r_raddr[w_rbank] <= r_raddr[w_rbank] + ADDR_ONE;
            end
            if (w_pop) r_oidx <= r_oidx + IDX_ONE;
            case (r_state)
                ST_LOAD: begin
                    r_rdy <= 1'b1;
                    if (w_acc) begin
                        r_widx <= r_widx + IDX_ONE;
                        if (r_widx == IDX_LAST) begin
                            r_state <= ST_START;
                            r_rdy   <= 1'b0;
                            r_start <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_CALC;
                    r_low   <= 1'b0;
                end
                ST_CALC: begin
                    if (!iRDY) r_low <= 1'b1;
                    else if (r_low) r_state <= ST_UNLOAD;
                end
                ST_UNLOAD: begin
                    if (w_last_out) begin
                        r_state <= ST_LOAD;
                        r_rdy   <= 1'b1;
                        r_ridx  <= '0;
                        r_fcnt  <= r_fcnt + 16'd1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    fht_skid_buf #(
        .D_BIT(D_BIT)
    ) u_skid (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iFLUSH (iCLR),
        .iPUSH  (r_inf),
        .iDATA  (w_push_data),
        .iPOP   (w_pop),
        .oDATA  (w_mdata),
        .oVALID (w_valid),
        .oCOUNT (w_cnt)
    );

endmodule
